// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: width defaults and FSM state encoding.
package voice_allocator_pkg;

    localparam int unsigned NOTE_WIDTH_DEF     = 6;
    localparam int unsigned DURATION_WIDTH_DEF = 6;

    typedef enum logic {
        VA_RUN   = 1'b0,
        VA_FLUSH = 1'b1
    } va_state_e;

endpackage

// File: rtl/voice_allocator_rr_free_picker.sv
// Round-robin free-voice picker: first free voice at or above rr_ptr, wrapping around.
// Purely combinational.
module voice_allocator_rr_free_picker #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned PTR_W      = 2
) (
    input  logic [NUM_VOICES-1:0] free,
    input  logic [PTR_W-1:0]      rr_ptr,
    output logic [NUM_VOICES-1:0] sel,
    output logic [PTR_W-1:0]      sel_idx,
    output logic                  any_free
);

    localparam int unsigned SW = PTR_W + 1;

    logic [SW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest free voice is the last write.
    always_comb begin
        sel      = '0;
        sel_idx  = '0;
        any_free = 1'b0;
        cand     = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NUM_VOICES)) begin
                cand = cand - SW'(NUM_VOICES);
            end
            if (free[cand[PTR_W-1:0]]) begin
                sel                     = '0;
                sel[cand[PTR_W-1:0]]    = 1'b1;
                sel_idx                 = cand[PTR_W-1:0];
                any_free                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: schedules sequencer notes onto NUM_VOICES note players round-robin.
// Optional build macro VOICE_STEAL_EN: when every voice is busy, steal the voice at rr_ptr
// instead of stalling the sequencer.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_VOICES     = 3,
    parameter int unsigned NOTE_WIDTH     = NOTE_WIDTH_DEF,
    parameter int unsigned DURATION_WIDTH = DURATION_WIDTH_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [NOTE_WIDTH-1:0]              req_note,
    input  logic [DURATION_WIDTH-1:0]          req_duration,
    input  logic [NUM_VOICES-1:0]              voice_done,
    output logic [NUM_VOICES-1:0]              voice_load,
    output logic [NUM_VOICES-1:0]              voice_kill,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_note,
    output logic [NUM_VOICES*DURATION_WIDTH-1:0] voice_duration,
    output logic [NUM_VOICES-1:0]              busy,
    output logic                               all_idle
);

    localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    va_state_e                          state_q, state_d;
    logic [NUM_VOICES-1:0]              busy_q, busy_d;
    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [NUM_VOICES-1:0]              load_q, load_d;
    logic [NUM_VOICES-1:0]              kill_q, kill_d;
    logic [NUM_VOICES*NOTE_WIDTH-1:0]   note_q, note_d;
    logic [NUM_VOICES*DURATION_WIDTH-1:0] dur_q, dur_d;

    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] pick_sel, sel;
    logic [PTR_W-1:0]      pick_idx, sel_idx;
    logic                  any_free, steal, in_run, accept, load_go;

    // A done pulse frees its voice in the same cycle it arrives.
    assign free   = ~busy_q | voice_done;
    assign in_run = (state_q == VA_RUN);

    voice_allocator_rr_free_picker #(
        .NUM_VOICES (NUM_VOICES),
        .PTR_W      (PTR_W)
    ) u_rr_free_picker (
        .free     (free),
        .rr_ptr   (rr_ptr_q),
        .sel      (pick_sel),
        .sel_idx  (pick_idx),
        .any_free (any_free)
    );

`ifdef VOICE_STEAL_EN
    // With nothing free, the voice at rr_ptr is the oldest allocation and gets stolen.
    assign steal     = ~any_free;
    assign sel       = any_free ? pick_sel : ({{(NUM_VOICES-1){1'b0}}, 1'b1} << rr_ptr_q);
    assign sel_idx   = any_free ? pick_idx : rr_ptr_q;
    assign req_ready = in_run;
`else
    assign steal     = 1'b0;
    assign sel       = pick_sel;
    assign sel_idx   = pick_idx;
    assign req_ready = in_run & any_free;
`endif

    assign accept  = req_valid & req_ready;
    assign load_go = accept & (|req_duration);

    // Next-state: allocation in RUN, one-cycle kill-all on entry to FLUSH.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        load_d   = '0;
        kill_d   = '0;
        note_d   = note_q;
        dur_d    = dur_q;
        unique case (state_q)
            VA_RUN: begin
                if (flush) begin
                    // Any accept in this cycle is dropped: no load, no busy set.
                    state_d  = VA_FLUSH;
                    kill_d   = busy_q;
                    busy_d   = '0;
                    rr_ptr_d = '0;
                end else begin
                    busy_d = busy_q & ~voice_done;
                    if (load_go) begin
                        busy_d   = busy_d | sel;
                        load_d   = sel;
                        kill_d   = steal ? sel : '0;
                        rr_ptr_d = (sel_idx == PTR_W'(NUM_VOICES - 1)) ? '0 : sel_idx + 1'b1;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (sel[i]) begin
                                note_d[i*NOTE_WIDTH +: NOTE_WIDTH]        = req_note;
                                dur_d[i*DURATION_WIDTH +: DURATION_WIDTH] = req_duration;
                            end
                        end
                    end
                end
            end
            VA_FLUSH: begin
                busy_d = '0;
                if (!flush) begin
                    state_d = VA_RUN;
                end
            end
            default: state_d = VA_RUN;
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= VA_RUN;
            busy_q   <= '0;
            rr_ptr_q <= '0;
            load_q   <= '0;
            kill_q   <= '0;
            note_q   <= '0;
            dur_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            load_q   <= load_d;
            kill_q   <= kill_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
        end
    end

    assign busy           = busy_q;
    assign voice_load     = load_q;
    assign voice_kill     = kill_q;
    assign voice_note     = note_q;
    assign voice_duration = dur_q;
    assign all_idle       = (busy_q == '0) & (load_q == '0) & in_run;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NUM_VOICES=3, 6-bit note/duration).
module tb_voice_allocator;

    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [NW-1:0]   req_note;
    logic [DW-1:0]   req_duration;
    logic [NV-1:0]   voice_done;
    logic [NV-1:0]   voice_load;
    logic [NV-1:0]   voice_kill;
    logic [NV*NW-1:0] voice_note;
    logic [NV*DW-1:0] voice_duration;
    logic [NV-1:0]   busy;
    logic            all_idle;

    int vectors;
    int miscompares;

    voice_allocator #(
        .NUM_VOICES     (NV),
        .NOTE_WIDTH     (NW),
        .DURATION_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_note       (req_note),
        .req_duration   (req_duration),
        .voice_done     (voice_done),
        .voice_load     (voice_load),
        .voice_kill     (voice_kill),
        .voice_note     (voice_note),
        .voice_duration (voice_duration),
        .busy           (busy),
        .all_idle       (all_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; voice_done = '0;
        req_valid = 1'b1; req_note = 6'd9; req_duration = 6'd9;
        step(); step();
        vectors++; if (busy !== 3'b000) begin $display("FAIL reset_busy got=%b exp=000", busy); miscompares++; end
        vectors++; if (voice_load !== 3'b000) begin $display("FAIL reset_load got=%b exp=000", voice_load); miscompares++; end
        vectors++; if (voice_kill !== 3'b000) begin $display("FAIL reset_kill got=%b exp=000", voice_kill); miscompares++; end
        vectors++; if (all_idle !== 1'b1) begin $display("FAIL reset_all_idle got=%b exp=1", all_idle); miscompares++; end
        vectors++; if (voice_note !== 18'd0 || voice_duration !== 18'd0) begin
            $display("FAIL reset_slots got note=%h dur=%h exp=0/0", voice_note, voice_duration); miscompares++; end
        reset = 1'b1; req_valid = 1'b0;
        step();
        vectors++; if (voice_load !== 3'b000 || busy !== 3'b000) begin
            $display("FAIL reset_no_accept got load=%b busy=%b exp=000/000", voice_load, busy); miscompares++; end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_note = 6'd10; req_duration = 6'd4;
        step();
        vectors++; if (voice_load !== 3'b001 || busy !== 3'b001) begin
            $display("FAIL b2b_first got load=%b busy=%b exp=001/001", voice_load, busy); miscompares++; end
        req_note = 6'd12; req_duration = 6'd2;
        step();
        vectors++; if (voice_load !== 3'b010 || busy !== 3'b011) begin
            $display("FAIL b2b_second got load=%b busy=%b exp=010/011", voice_load, busy); miscompares++; end
        req_note = 6'd15; req_duration = 6'd8;
        step();
        req_valid = 1'b0;
        #1;
        vectors++; if (voice_load !== 3'b100 || busy !== 3'b111) begin
            $display("FAIL b2b_third got load=%b busy=%b exp=100/111", voice_load, busy); miscompares++; end
        vectors++; if (req_ready !== 1'b0) begin $display("FAIL b2b_full_ready got=%b exp=0", req_ready); miscompares++; end
        vectors++; if (voice_note !== {6'd15, 6'd12, 6'd10}) begin
            $display("FAIL b2b_notes got=%h exp=%h", voice_note, {6'd15, 6'd12, 6'd10}); miscompares++; end
        vectors++; if (voice_duration !== {6'd8, 6'd2, 6'd4}) begin
            $display("FAIL b2b_durations got=%h exp=%h", voice_duration, {6'd8, 6'd2, 6'd4}); miscompares++; end
        vectors++; if (all_idle !== 1'b0) begin $display("FAIL b2b_all_idle got=%b exp=0", all_idle); miscompares++; end
    endtask

    task automatic test_done_realloc();
        // busy=111, rr_ptr=0; voice 1 finishes while a new note arrives
        voice_done = 3'b010; req_valid = 1'b1; req_note = 6'd30; req_duration = 6'd5;
        #1;
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL realloc_ready got=%b exp=1", req_ready); miscompares++; end
        step();
        voice_done = '0; req_valid = 1'b0;
        vectors++; if (voice_load !== 3'b010 || busy !== 3'b111) begin
            $display("FAIL realloc_load got load=%b busy=%b exp=010/111", voice_load, busy); miscompares++; end
        vectors++; if (voice_note[1*NW +: NW] !== 6'd30 || voice_duration[1*DW +: DW] !== 6'd5) begin
            $display("FAIL realloc_slot1 got note=%0d dur=%0d exp=30/5",
                     voice_note[1*NW +: NW], voice_duration[1*DW +: DW]); miscompares++; end
    endtask

    task automatic test_steal();
        // busy=111, rr_ptr=2
        req_valid = 1'b1; req_note = 6'd40; req_duration = 6'd6;
        #1;
`ifdef VOICE_STEAL_EN
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL steal_ready got=%b exp=1", req_ready); miscompares++; end
        step();
        req_valid = 1'b0;
        vectors++; if (voice_kill !== 3'b100 || voice_load !== 3'b100) begin
            $display("FAIL steal_pulses got kill=%b load=%b exp=100/100", voice_kill, voice_load); miscompares++; end
        vectors++; if (voice_note[2*NW +: NW] !== 6'd40 || busy !== 3'b111) begin
            $display("FAIL steal_slot2 got note=%0d busy=%b exp=40/111", voice_note[2*NW +: NW], busy); miscompares++; end
`else
        vectors++; if (req_ready !== 1'b0) begin $display("FAIL nosteal_ready got=%b exp=0", req_ready); miscompares++; end
        step();
        req_valid = 1'b0;
        vectors++; if (voice_kill !== 3'b000 || voice_load !== 3'b000) begin
            $display("FAIL nosteal_pulses got kill=%b load=%b exp=000/000", voice_kill, voice_load); miscompares++; end
        vectors++; if (voice_note[2*NW +: NW] !== 6'd15 || busy !== 3'b111) begin
            $display("FAIL nosteal_slot2 got note=%0d busy=%b exp=15/111", voice_note[2*NW +: NW], busy); miscompares++; end
`endif
    endtask

    task automatic test_flush();
        voice_done = 3'b010;
        step();
        voice_done = '0;
        vectors++; if (busy !== 3'b101) begin $display("FAIL flush_pre_busy got=%b exp=101", busy); miscompares++; end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        vectors++; if (voice_kill !== 3'b101 || busy !== 3'b000) begin
            $display("FAIL flush_kill got kill=%b busy=%b exp=101/000", voice_kill, busy); miscompares++; end
        vectors++; if (req_ready !== 1'b0 || all_idle !== 1'b0) begin
            $display("FAIL flush_state got ready=%b idle=%b exp=0/0", req_ready, all_idle); miscompares++; end
        step();
        vectors++; if (voice_kill !== 3'b000 || all_idle !== 1'b1 || req_ready !== 1'b1) begin
            $display("FAIL flush_exit got kill=%b idle=%b ready=%b exp=000/1/1",
                     voice_kill, all_idle, req_ready); miscompares++; end
    endtask

    task automatic test_rest();
        // rr_ptr=0 after flush, all voices free
        req_valid = 1'b1; req_note = 6'd7; req_duration = 6'd0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL rest_ready got=%b exp=1", req_ready); miscompares++; end
        step();
        vectors++; if (voice_load !== 3'b000 || busy !== 3'b000 || all_idle !== 1'b1) begin
            $display("FAIL rest_dropped got load=%b busy=%b idle=%b exp=000/000/1",
                     voice_load, busy, all_idle); miscompares++; end
        req_note = 6'd20; req_duration = 6'd3;
        step();
        req_valid = 1'b0;
        vectors++; if (voice_load !== 3'b001 || busy !== 3'b001) begin
            $display("FAIL rest_next_note got load=%b busy=%b exp=001/001", voice_load, busy); miscompares++; end
        vectors++; if (voice_note[0 +: NW] !== 6'd20 || voice_duration[0 +: DW] !== 6'd3) begin
            $display("FAIL rest_slot0 got note=%0d dur=%0d exp=20/3", voice_note[0 +: NW],
                     voice_duration[0 +: DW]); miscompares++; end
        vectors++; if (voice_note[1*NW +: NW] !== 6'd30) begin
            $display("FAIL slot1_hold got=%0d exp=30", voice_note[1*NW +: NW]); miscompares++; end
    endtask

    task automatic test_flush_hold();
        // busy=001; hold flush two cycles, only the first kills
        flush = 1'b1;
        step();
        vectors++; if (voice_kill !== 3'b001 || busy !== 3'b000) begin
            $display("FAIL hold_first got kill=%b busy=%b exp=001/000", voice_kill, busy); miscompares++; end
        step();
        flush = 1'b0;
        vectors++; if (voice_kill !== 3'b000 || req_ready !== 1'b0) begin
            $display("FAIL hold_repeat got kill=%b ready=%b exp=000/0", voice_kill, req_ready); miscompares++; end
        step();
        vectors++; if (all_idle !== 1'b1 || voice_kill !== 3'b000) begin
            $display("FAIL hold_exit got idle=%b kill=%b exp=1/000", all_idle, voice_kill); miscompares++; end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_back_to_back();
        test_done_realloc();
        test_steal();
        test_flush();
        test_rest();
        test_flush_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
